kws_requant_seq: RTL and testbench

Multi-cycle command sequencer for the KWS CFU. It owns the accumulator and the per-channel requantization config registers. It drives the external MAC, SRDHM and RCDBPOT combinational units through one shared work register, turning a single FINALIZE command into a bias → SRDHM → rounding-shift → offset → clamp sequence. It sits between the CPU CFU handshake and the datapath units, and replaces the single-cycle accumulate/respond logic at the CFU top level.

---
 rtl/kws_requant_seq.sv | 180 ++++++++++++++++++
 tb/tb_kws_requant_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/kws_requant_seq.sv
// KWS CFU command sequencer: accumulator, requant config and FINALIZE pipeline.
// Define REQUANT_SEQ_CLAMP_EN to enable the act_min/act_max output clamp.
module kws_requant_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0,
    output logic        rsp_payload_response_ok,
    output logic [31:0] mac_acc,
    input  logic [31:0] mac_acc_next,
    output logic [31:0] srdhm_top,
    output logic [31:0] srdhm_bottom,
    input  logic [31:0] srdhm_out,
    output logic [31:0] rcdbpot_dividend,
    output logic [31:0] rcdbpot_exponent,
    input  logic [31:0] rcdbpot_out
);

    typedef enum logic [1:0] {IDLE, SRDHM, RCD, CLAMP} state_t;

    state_t state;
    state_t state_next;

    logic [31:0] acc;
    logic [31:0] work;
    logic [31:0] result;
    logic [31:0] bias;
    logic [31:0] multiplier;
    logic [31:0] shift;
    logic [31:0] out_offset;
`ifdef REQUANT_SEQ_CLAMP_EN
    logic signed [31:0] act_min;
    logic signed [31:0] act_max;
    logic signed [31:0] lo_bound;
`endif

    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        fire;
    logic        is_mac;
    logic        is_clear;
    logic        is_cfg;
    logic        is_read;
    logic        is_fin;
    logic [31:0] rsp_data;
    logic [31:0] lshift_amt;
    logic [31:0] shifted;
    logic [31:0] final_val;
    logic        unused_inputs_1;

    assign funct3 = cmd_payload_function_id[2:0];
    assign funct7 = cmd_payload_function_id[9:3];
    assign unused_inputs_1 = ^cmd_payload_inputs_1;

    assign is_mac   = (funct3 == 3'd0);
    assign is_clear = (funct3 == 3'd1);
    assign is_cfg   = (funct3 == 3'd2);
    assign is_read  = (funct3 == 3'd3);
    assign is_fin   = (funct3 == 3'd4);

    assign fire = cmd_valid && cmd_ready;

    // Positive shift scales up before SRDHM, negative shift rounds down after it.
    assign lshift_amt       = shift[31] ? 32'd0 : shift;
    assign rcdbpot_exponent = shift[31] ? (32'd0 - shift) : 32'd0;
    assign shifted          = (acc + bias) << lshift_amt;

    assign mac_acc                 = acc;
    assign srdhm_top               = work;
    assign srdhm_bottom            = multiplier;
    assign rcdbpot_dividend        = work;
    assign rsp_payload_outputs_0   = result;
    assign rsp_payload_response_ok = 1'b1;

`ifdef REQUANT_SEQ_CLAMP_EN
    always_comb begin
        lo_bound  = ($signed(work) > act_min) ? $signed(work) : act_min;
        final_val = (lo_bound < act_max) ? lo_bound : act_max;
    end
`else
    assign final_val = work;
`endif

    always_comb begin
        rsp_data = 32'd0;
        unique case (1'b1)
            is_mac:   rsp_data = mac_acc_next;
            is_clear: rsp_data = 32'd0;
            is_cfg:   rsp_data = cmd_payload_inputs_0;
            is_read:  rsp_data = acc;
            default:  rsp_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (fire && is_fin) state_next = SRDHM;
            SRDHM:   state_next = RCD;
            RCD:     state_next = CLAMP;
            CLAMP:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE) && !rsp_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc        <= 32'd0;
            work       <= 32'd0;
            result     <= 32'd0;
            rsp_valid  <= 1'b0;
            bias       <= 32'd0;
            multiplier <= 32'h4000_0000;
            shift      <= 32'd0;
            out_offset <= 32'd0;
`ifdef REQUANT_SEQ_CLAMP_EN
            act_min    <= -32'sd128;
            act_max    <= 32'sd127;
`endif
        end else begin
            if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            if (fire) begin
                unique case (1'b1)
                    is_mac:   acc <= mac_acc_next;
                    is_clear: acc <= 32'd0;
                    is_cfg: begin
                        case (funct7)
                            7'd0: bias       <= cmd_payload_inputs_0;
                            7'd1: multiplier <= cmd_payload_inputs_0;
                            7'd2: shift      <= cmd_payload_inputs_0;
                            7'd3: out_offset <= cmd_payload_inputs_0;
`ifdef REQUANT_SEQ_CLAMP_EN
                            7'd4: act_min    <= cmd_payload_inputs_0;
                            7'd5: act_max    <= cmd_payload_inputs_0;
`endif
                            default: ;
                        endcase
                    end
                    is_fin:   work <= shifted;
                    default:  ;
                endcase
                if (!is_fin) begin
                    rsp_valid <= 1'b1;
                    result    <= rsp_data;
                end
            end
            unique case (state)
                SRDHM: work <= srdhm_out;
                RCD:   work <= rcdbpot_out + out_offset;
                CLAMP: begin
                    result    <= final_val;
                    acc       <= 32'd0;
                    rsp_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_kws_requant_seq.sv
// Directed bench for kws_requant_seq with golden MAC/SRDHM/RCDBPOT models.
`timescale 1ns/1ps
module tb_kws_requant_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  fid;
    logic [31:0] in0;
    logic [31:0] in1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_ok;
    logic [31:0] mac_acc;
    logic [31:0] mac_acc_next;
    logic [31:0] srdhm_top;
    logic [31:0] srdhm_bottom;
    logic [31:0] srdhm_out;
    logic [31:0] rcd_div;
    logic [31:0] rcd_exp;
    logic [31:0] rcd_out;

    int vectors = 0;
    int fails = 0;

`ifdef REQUANT_SEQ_CLAMP_EN
    localparam logic [31:0] E_BIG  = 32'd127;
    localparam logic [31:0] E_100K = 32'd127;
    localparam logic [31:0] E_INV  = -32'sd30;
    localparam logic [31:0] E_BP   = -32'sd30;
`else
    localparam logic [31:0] E_BIG  = 32'd1024;
    localparam logic [31:0] E_100K = 32'd50000;
    localparam logic [31:0] E_INV  = 32'd0;
    localparam logic [31:0] E_BP   = 32'd3;
`endif

    always #5 clk = ~clk;

    function automatic logic [31:0] f_srdhm(logic signed [31:0] a, logic signed [31:0] b);
        longint ab;
        longint nudge;
        longint q;
        if (a == 32'sh8000_0000 && b == 32'sh8000_0000) return 32'h7fff_ffff;
        ab = longint'(a) * longint'(b);
        nudge = (ab >= 0) ? (64'sd1 <<< 30) : (64'sd1 - (64'sd1 <<< 30));
        q = (ab + nudge) / 64'sd2147483648;
        return q[31:0];
    endfunction

    function automatic logic [31:0] f_rcd(logic signed [31:0] x, logic [31:0] e);
        logic signed [31:0] mask;
        logic signed [31:0] rem;
        logic signed [31:0] thr;
        int sh;
        sh = (e > 32'd30) ? 30 : int'(e);
        mask = (32'sd1 <<< sh) - 32'sd1;
        rem = x & mask;
        thr = (mask >>> 1) + ((x < 0) ? 32'sd1 : 32'sd0);
        return (x >>> sh) + ((rem > thr) ? 32'sd1 : 32'sd0);
    endfunction

    assign mac_acc_next = mac_acc + in0;
    assign srdhm_out    = f_srdhm(srdhm_top, srdhm_bottom);
    assign rcd_out      = f_rcd(rcd_div, rcd_exp);

    kws_requant_seq dut (
        .clk                     (clk),
        .reset                   (reset),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (fid),
        .cmd_payload_inputs_0    (in0),
        .cmd_payload_inputs_1    (in1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_outputs_0   (rsp_data),
        .rsp_payload_response_ok (rsp_ok),
        .mac_acc                 (mac_acc),
        .mac_acc_next            (mac_acc_next),
        .srdhm_top               (srdhm_top),
        .srdhm_bottom            (srdhm_bottom),
        .srdhm_out               (srdhm_out),
        .rcdbpot_dividend        (rcd_div),
        .rcdbpot_exponent        (rcd_exp),
        .rcdbpot_out             (rcd_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, " drop"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    task automatic cmd(input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] d, input logic [31:0] exp,
                       input string tag);
        @(negedge clk);
        chk({tag, " rdy"}, {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        fid = {f7, f3};
        in0 = d;
        in1 = $urandom;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk({tag, " vld"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, " data"}, rsp_data, exp);
        handshake(tag);
    endtask

    task automatic fin(input logic [31:0] exp, input int hold, input string tag);
        int lat;
        @(negedge clk);
        chk({tag, " rdy"}, {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        fid = {7'd0, 3'd4};
        in0 = $urandom;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk({tag, " busy"}, {31'd0, cmd_ready}, 32'd0);
        lat = 0;
        while (!rsp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " lat"}, lat, 32'd3);
        chk({tag, " data"}, rsp_data, exp);
        if (hold > 0) begin
            cmd_valid = 1'b1;
            fid = {7'd0, 3'd0};
            in0 = 32'd9;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk({tag, " hold vld"}, {31'd0, rsp_valid}, 32'd1);
                chk({tag, " hold data"}, rsp_data, exp);
                chk({tag, " hold rdy"}, {31'd0, cmd_ready}, 32'd0);
            end
            cmd_valid = 1'b0;
        end
        handshake(tag);
    endtask

    initial begin
        int seen;
        reset = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        fid = '0;
        in0 = '0;
        in1 = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst rdy", {31'd0, cmd_ready}, 32'd1);
        chk("rst ok", {31'd0, rsp_ok}, 32'd1);
        chk("rst vld", {31'd0, rsp_valid}, 32'd0);
        chk("rst data", rsp_data, 32'd0);
        chk("rst acc", mac_acc, 32'd0);
        chk("rst mult", srdhm_bottom, 32'h4000_0000);
        chk("rst exp", rcd_exp, 32'd0);

        cmd(7'd0, 3'd3, 32'd0, 32'd0, "read0");
        cmd(7'd0, 3'd0, 32'd7, 32'd7, "mac7");
        cmd(7'd0, 3'd0, -32'sd2, 32'd5, "mac-2");
        cmd(7'd0, 3'd3, 32'd0, 32'd5, "read5");
        cmd(7'd0, 3'd1, 32'd0, 32'd0, "clear");
        cmd(7'd0, 3'd7, 32'd55, 32'd0, "op7");
        cmd(7'd9, 3'd2, 32'd77, 32'd77, "cfg nop");

        cmd(7'd0, 3'd2, 32'd24, 32'd24, "cfg bias");
        cmd(7'd2, 3'd2, -32'sd2, -32'sd2, "cfg shift");
        chk("exp2", rcd_exp, 32'd2);
        cmd(7'd3, 3'd2, -32'sd128, -32'sd128, "cfg off");
        cmd(7'd0, 3'd0, 32'd1000, 32'd1000, "mac1000");
        fin(32'd0, 0, "fin zero");
        cmd(7'd0, 3'd3, 32'd0, 32'd0, "acc cleared");

        cmd(7'd2, 3'd2, 32'd1, 32'd1, "cfg shift1");
        cmd(7'd3, 3'd2, 32'd0, 32'd0, "cfg off0");
        cmd(7'd0, 3'd0, 32'd1000, 32'd1000, "mac1000b");
        fin(E_BIG, 0, "fin big");

        cmd(7'd0, 3'd2, 32'd0, 32'd0, "cfg bias0");
        cmd(7'd2, 3'd2, 32'd0, 32'd0, "cfg shift0");
        cmd(7'd0, 3'd0, 32'd100000, 32'd100000, "mac100k");
        fin(E_100K, 0, "fin 100k");

        cmd(7'd4, 3'd2, -32'sd20, -32'sd20, "cfg amin");
        cmd(7'd5, 3'd2, -32'sd30, -32'sd30, "cfg amax");
        fin(E_INV, 0, "fin inv");

        cmd(7'd0, 3'd0, 32'd5, 32'd5, "mac5");
        fin(E_BP, 5, "fin bp");
        cmd(7'd0, 3'd3, 32'd0, 32'd0, "acc after bp");

        cmd(7'd0, 3'd2, 32'd24, 32'd24, "cfg bias24");
        cmd(7'd0, 3'd0, 32'd1000, 32'd1000, "mac abort");
        @(negedge clk);
        cmd_valid = 1'b1;
        fid = {7'd0, 3'd4};
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid) seen++;
            @(posedge clk); #1;
        end
        chk("abort no rsp", seen, 32'd0);
        chk("abort rdy", {31'd0, cmd_ready}, 32'd1);
        cmd(7'd0, 3'd3, 32'd0, 32'd0, "abort acc");
        cmd(7'd0, 3'd0, 32'd100000, 32'd100000, "mac100k b");
        fin(E_100K, 0, "fin default");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
